// File: rtl/countdown_timer.sv
// Loadable MM:SS BCD countdown timer with run/pause, expiry pulse and done level.
// Digit outputs follow the HEX0..HEX3 4-bit-per-digit convention of the stopwatch.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        run,
  output logic [3:0]  HEX0,
  output logic [3:0]  HEX1,
  output logic [3:0]  HEX2,
  output logic [3:0]  HEX3,
  output logic        running,
  output logic        done,
  output logic        expired
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          at_one;
  logic          is_zero;
  logic [15:0]   digits;
  logic [15:0]   dec;

  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    logic [15:0] r;
    r[15:12] = (v[15:12] > 4'd5) ? 4'd5 : v[15:12];
    r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
    r[7:4]   = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
    r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
    return r;
  endfunction

  always_comb begin
    digits  = {HEX3, HEX2, HEX1, HEX0};
    tick    = (state == COUNT) && run && (presc == TMAX);
    at_one  = (digits == 16'h0001);
    is_zero = (digits == 16'h0000);
  end

  // BCD borrow chain; 00:00 is never decremented, so no underflow handling.
  always_comb begin
    dec = digits;
    if (HEX0 != 4'd0) begin
      dec[3:0] = HEX0 - 4'd1;
    end else begin
      dec[3:0] = 4'd9;
      if (HEX1 != 4'd0) begin
        dec[7:4] = HEX1 - 4'd1;
      end else begin
        dec[7:4] = 4'd5;
        if (HEX2 != 4'd0) begin
          dec[11:8] = HEX2 - 4'd1;
        end else begin
          dec[11:8]  = 4'd9;
          dec[15:12] = HEX3 - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      presc   <= '0;
      {HEX3, HEX2, HEX1, HEX0} <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        {HEX3, HEX2, HEX1, HEX0} <= clamp_bcd(load_val);
        presc   <= '0;
        state   <= IDLE;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run && !is_zero) begin
              state   <= COUNT;
              running <= 1'b1;
            end
          end
          COUNT: begin
            if (!run) begin
              state   <= HOLD;
              running <= 1'b0;
            end else if (tick) begin
              presc <= '0;
              {HEX3, HEX2, HEX1, HEX0} <= dec;
              if (at_one) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
                expired <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          HOLD: begin
            if (run) begin
              state   <= COUNT;
              running <= 1'b1;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable BCD countdown timer in minutes:seconds form (MM:SS, 00:00–59:59). It decrements once per second of run time and flags expiry at 00:00. It is the count-down counterpart of the free-running up-counting stopwatch. Its digit outputs use the same 4-bit-per-digit HEX0..HEX3 convention, so they feed the same seven-segment drivers.

## Interface
- TICKS_PER_SEC, default 50000000: clk cycles per counted second; must be ≥ 2.
- clk  input  1  system clock (50 MHz nominal)
- reset  input  1  asynchronous, active-high; clears all state
- load  input  1  level; capture load_val this cycle; overrides run
- load_val  input  16  BCD {tensMins[15:12], mins[11:8], tensSecs[7:4], secs[3:0]}
- run  input  1  level; 1 = count, 0 = pause
- HEX0  output  4  seconds ones digit (0–9)
- HEX1  output  4  seconds tens digit (0–5)
- HEX2  output  4  minutes ones digit (0–9)
- HEX3  output  4  minutes tens digit (0–5)
- running  output  1  1 while state is COUNT
- done  output  1  level; 1 while state is DONE
- expired  output  1  single-cycle pulse on reaching 00:00 by counting

## Operation
- States: IDLE, COUNT, HOLD, DONE. Reset value is IDLE. All outputs are registered.
- Transition priority is: reset, then load, then the rules below.
- Any state, load=1 → IDLE next cycle:
  - digits take the clamped load_val;
  - the prescaler is cleared.
- Clamping on load, per digit:
  - tensMins and tensSecs values >5 become 5;
  - mins and secs values >9 become 9.
  - Example: 16'hFAFA loads 59:59.
- IDLE:
  - run=1 and value ≠ 00:00 → COUNT;
  - run=1 and value = 00:00 → stay in IDLE.
- COUNT:
  - run=0 → HOLD;
  - a tick with value 00:01 → DONE;
  - otherwise stay in COUNT.
- HOLD:
  - run=1 → COUNT;
  - the prescaler and digits are frozen.
- DONE:
  - digits are held at 00:00; run is ignored;
  - it is left only by load or reset.
- Prescaler:
  - width is $clog2(TICKS_PER_SEC);
  - it increments only in cycles where state=COUNT and run=1;
  - tick = (prescaler == TICKS_PER_SEC-1) in such a cycle; on tick the prescaler wraps to 0.
  - A second is exactly TICKS_PER_SEC counting cycles.
- Decrement on tick, BCD borrow chain:
  - secs 0→9 borrows from tensSecs;
  - tensSecs 0→5 borrows from mins;
  - mins 0→9 borrows from tensMins;
  - otherwise the digit decrements by 1.
- Tick at 00:01:
  - digits go to 00:00 and state goes to DONE;
  - there is no wrap to 59:59.
- The counter never underflows. 00:00 is only reachable in COUNT via the 00:01 tick.

## Timing
- Reset values: HEX0–HEX3 = 0, running=0, done=0, expired=0, prescaler=0, state IDLE.
- Reset is asynchronous: outputs clear immediately on assertion, including mid-count.
- load is sampled on the clk edge; new digits are visible the cycle after.
- Start latency from IDLE with run=1:
  - COUNT is entered on the next edge;
  - the first tick occurs TICKS_PER_SEC counting cycles after COUNT entry.
- Pause:
  - deasserting run in COUNT takes effect immediately for the prescaler (no increment that cycle);
  - state shows HOLD next cycle.
  - Resume continues from the held prescaler value, so no partial second is lost or repeated.
- expired is high for exactly the one cycle after the edge on which the digits became 00:00. done rises in the same cycle and stays high.
- load on the same cycle as a tick: load wins and the tick is discarded.
- run=0 on the same cycle as a tick: not possible, because tick requires run=1.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset mid-count at 01:30 → HEX all 0, running=0, done=0, expired=0 immediately; state IDLE.
- Countdown with borrow:
  - stimulus: load 16'h0102, then hold run=1;
  - after COUNT entry plus 4 cycles → 01:01; plus 8 → 01:00; plus 12 → 00:59 (HEX3=0, HEX2=0, HEX1=5, HEX0=9).
- Expiry:
  - stimulus: load 16'h0002, then run=1;
  - at the 8th counting cycle → 00:00 with a one-cycle expired pulse, done=1, running=0;
  - a further 20 cycles of run → no change, no second pulse.
- Pause/resume:
  - stimulus: load 00:05, run 2 counting cycles, run=0 for 10 cycles, then run=1;
  - HEX0 stays 5 during the pause and becomes 4 exactly 2 counting cycles after resume.
- Clamp and zero-load:
  - load 16'hFAFA → 59:59;
  - load 16'h0000 then run=1 → stays IDLE, expired=0, done=0.
- Load overrides:
  - load 16'h0030 asserted on the exact tick cycle while counting 00:10 → next cycle shows 00:30, state IDLE, prescaler 0;
  - load from DONE → done=0 next cycle.
